// File: rtl/router_fsm.sv
// Router packet-sequencing FSM: address decode, header/payload/parity load, full stall and drain wait.
// Optional WAIT_TILL_EMPTY watchdog with drop_pkt pulse is enabled by defining ROUTER_FSM_TIMEOUT_EN.
module router_fsm #(
    parameter int TIMEOUT_MAX = 63
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pkt_valid,
    input  logic [1:0] data_in,
    input  logic       fifo_full,
    input  logic       fifo_empty_0,
    input  logic       fifo_empty_1,
    input  logic       fifo_empty_2,
    input  logic       soft_rst_0,
    input  logic       soft_rst_1,
    input  logic       soft_rst_2,
    input  logic       parity_done,
    input  logic       low_pkt_valid,
    output logic       detect_add,
    output logic       lfd_state,
    output logic       ld_state,
    output logic       laf_state,
    output logic       full_state,
    output logic       write_enb_reg,
    output logic       rst_int_reg,
    output logic       busy,
    output logic       drop_pkt
);
    typedef enum logic [2:0] {
        DA  = 3'd0,
        LFD = 3'd1,
        LD  = 3'd2,
        LP  = 3'd3,
        FFS = 3'd4,
        LAF = 3'd5,
        WTE = 3'd6,
        CPE = 3'd7
    } state_t;

    typedef logic [$clog2(TIMEOUT_MAX + 1)-1:0] cnt_t;

    state_t     state;
    state_t     state_n;
    logic [1:0] addr_q;
    logic       soft_hit;
    logic       empty_addr;
    logic       empty_in;
`ifdef ROUTER_FSM_TIMEOUT_EN
    cnt_t       wait_cnt;
    logic       timeout;
`endif

    // Address 3 is never latched, so it maps to "no soft reset" and "not empty".
    always_comb begin
        soft_hit   = 1'b0;
        empty_addr = 1'b0;
        empty_in   = 1'b0;
        case (addr_q)
            2'd0:    begin soft_hit = soft_rst_0; empty_addr = fifo_empty_0; end
            2'd1:    begin soft_hit = soft_rst_1; empty_addr = fifo_empty_1; end
            2'd2:    begin soft_hit = soft_rst_2; empty_addr = fifo_empty_2; end
            default: begin soft_hit = 1'b0;       empty_addr = 1'b0;         end
        endcase
        case (data_in)
            2'd0:    empty_in = fifo_empty_0;
            2'd1:    empty_in = fifo_empty_1;
            2'd2:    empty_in = fifo_empty_2;
            default: empty_in = 1'b0;
        endcase
    end

    always_comb begin
        state_n = state;
`ifdef ROUTER_FSM_TIMEOUT_EN
        timeout = 1'b0;
`endif
        case (state)
            DA:  if (pkt_valid && data_in != 2'd3) state_n = empty_in ? LFD : WTE;
            WTE: begin
                if (empty_addr) begin
                    state_n = LFD;
                end
`ifdef ROUTER_FSM_TIMEOUT_EN
                else if (wait_cnt == cnt_t'(TIMEOUT_MAX)) begin
                    state_n = DA;
                    timeout = 1'b1;
                end
`endif
            end
            LFD: state_n = LD;
            LD:  begin
                if (fifo_full)       state_n = FFS;
                else if (!pkt_valid) state_n = LP;
            end
            FFS: if (!fifo_full) state_n = LAF;
            LAF: begin
                if (parity_done)        state_n = DA;
                else if (low_pkt_valid) state_n = LP;
                else                    state_n = LD;
            end
            LP:  state_n = CPE;
            CPE: state_n = fifo_full ? FFS : DA;
            default: state_n = DA;
        endcase
        // Destination soft reset aborts the packet from any non-idle state.
        if (state != DA && soft_hit) begin
            state_n = DA;
`ifdef ROUTER_FSM_TIMEOUT_EN
            timeout = 1'b0;
`endif
        end
    end

    // Outputs are registered decodes of the next state, so they track the state register exactly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= DA;
            addr_q        <= 2'd0;
            detect_add    <= 1'b1;
            lfd_state     <= 1'b0;
            ld_state      <= 1'b0;
            laf_state     <= 1'b0;
            full_state    <= 1'b0;
            write_enb_reg <= 1'b0;
            rst_int_reg   <= 1'b0;
            busy          <= 1'b0;
        end else begin
            state <= state_n;
            if (state == DA && state_n != DA) addr_q <= data_in;
            detect_add    <= (state_n == DA);
            lfd_state     <= (state_n == LFD);
            ld_state      <= (state_n == LD);
            laf_state     <= (state_n == LAF);
            full_state    <= (state_n == FFS);
            write_enb_reg <= (state_n == LD) || (state_n == LP) || (state_n == LAF);
            rst_int_reg   <= (state_n == CPE);
            busy          <= (state_n != DA) && (state_n != LD);
        end
    end

`ifdef ROUTER_FSM_TIMEOUT_EN
    // Counter sits at zero outside WTE, so every WTE visit starts counting from 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= '0;
            drop_pkt <= 1'b0;
        end else begin
            drop_pkt <= timeout;
            if (state == WTE) wait_cnt <= wait_cnt + 1'b1;
            else              wait_cnt <= '0;
        end
    end
`else
    assign drop_pkt = 1'b0;
`endif

endmodule

// File: doc/router_fsm.md
# router_fsm

Packet-sequencing controller for the router. It decodes the destination address of each incoming packet and sequences header, payload and parity loading into the register stage. It stalls on FIFO-full and waits for a busy destination FIFO to drain. It aborts the packet when the destination port's soft reset fires. It sits between the input port and the synchronizer/register stage, driving the synchronizer's `detect_add` and `wr_en_reg`.

## Interface
- `TIMEOUT_MAX`, 63: last count value of the WAIT_TILL_EMPTY watchdog; only used when `ROUTER_FSM_TIMEOUT_EN` is defined.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `pkt_valid` in 1: the input byte stream is valid; deasserts on the parity byte.
- `data_in` in 2: destination address (header bits [1:0]); sampled only in DECODE_ADDRESS.
- `fifo_full` in 1: selected FIFO is full (from the synchronizer).
- `fifo_empty_0`, `fifo_empty_1`, `fifo_empty_2` in 1 each: output FIFO empty flags.
- `soft_rst_0`, `soft_rst_1`, `soft_rst_2` in 1 each: per-port soft resets (from the synchronizer).
- `parity_done` in 1: the register stage has captured the parity byte.
- `low_pkt_valid` in 1: `pkt_valid` fell while the FIFO was full.
- `detect_add`, `lfd_state`, `ld_state`, `laf_state`, `full_state` out 1 each: state decodes.
- `write_enb_reg` out 1: write request to the synchronizer.
- `rst_int_reg` out 1: clears the register stage's internal parity/low-valid flags.
- `busy` out 1: input port must hold the current byte.
- `drop_pkt` out 1: one-cycle pulse when a packet is aborted by the watchdog; tied 0 without the macro.

## Operation
- The state register is 3 bits, with 8 states.
  - DECODE_ADDRESS (DA) is the reset state.
  - The other states are LOAD_FIRST_DATA (LFD), LOAD_DATA (LD), LOAD_PARITY (LP), FIFO_FULL_STATE (FFS), LOAD_AFTER_FULL (LAF), WAIT_TILL_EMPTY (WTE) and CHECK_PARITY_ERROR (CPE).
- `addr_q` (2 bits, reset 0) latches `data_in` on every edge where DA exits; it is held otherwise.
- Transitions, in priority order:
  - Any state except DA: if `soft_rst_<addr_q>` is high, go to DA. This overrides every other transition.
  - DA:
    - `pkt_valid` high, `data_in` in 0..2 and `fifo_empty_<data_in>` high: go to LFD.
    - `pkt_valid` high, `data_in` in 0..2 and `fifo_empty_<data_in>` low: go to WTE.
    - `data_in`=3 or `pkt_valid` low: stay in DA.
  - WTE: `fifo_empty_<addr_q>` high goes to LFD; otherwise stay.
  - LFD: always go to LD.
  - LD: `fifo_full` high goes to FFS (this beats the `pkt_valid` check). Otherwise `pkt_valid` low goes to LP; else stay.
  - FFS: `fifo_full` low goes to LAF; otherwise stay.
  - LAF:
    - `parity_done` high: go to DA.
    - `parity_done` low and `low_pkt_valid` high: go to LP.
    - Otherwise: go to LD.
  - LP: always go to CPE.
  - CPE: `fifo_full` high goes to FFS; otherwise go to DA.
- Outputs are pure Moore decodes of the state register, with no glitch paths from the inputs:
  - `detect_add` = DA; `lfd_state` = LFD; `ld_state` = LD; `laf_state` = LAF; `full_state` = FFS.
  - `write_enb_reg` = LD | LP | LAF.
  - `rst_int_reg` = CPE.
  - `busy` = every state except DA and LD.
- Reset values:
  - State is DA and `addr_q`=0.
  - `detect_add`=1; every other output is 0.

## Timing
- Header sampled at edge N in DA with an empty FIFO:
  - `lfd_state`=1 and `busy`=1 during cycle N+1.
  - `ld_state`=1, `write_enb_reg`=1 and `busy`=0 from N+2.
- `pkt_valid` low sampled in LD at edge M: LP during M+1, CPE during M+2, DA during M+3 (if the FIFO is not full).
- `fifo_full` sampled high in LD: FFS from the next cycle and `write_enb_reg` drops in that same cycle. Recovery to LAF happens one cycle after `fifo_full` falls.
- Soft reset takes effect at the next edge: DA in the following cycle. `addr_q` is not cleared.
- Asserting `rst` mid-packet immediately forces DA and the reset values, without waiting for a clock edge.

## Configuration
- `ROUTER_FSM_TIMEOUT_EN` defined:
  - A 6-bit `wait_cnt` clears on entry to WTE and increments on each cycle spent in WTE.
  - If WTE sees `fifo_empty_<addr_q>` low with `wait_cnt`==`TIMEOUT_MAX`, the next state is DA.
  - `drop_pkt` is registered and is 1 for exactly the first cycle back in DA.
  - Empty beats timeout when both occur on the same edge.
  - Soft reset still has top priority.
- `ROUTER_FSM_TIMEOUT_EN` undefined: no counter, WTE waits indefinitely, and `drop_pkt` is constant 0.

## Test plan
- Reset then idle: `rst`=1 -> `detect_add`=1, all other outputs 0. Release with `pkt_valid`=0 -> stays in DA.
- Packet to port 1, FIFO1 empty, 4 payload bytes then parity:
  - Required sequence: DA, LFD, LD×4, LP, CPE, DA.
  - `write_enb_reg` high for exactly 5 cycles (LD×4 plus LP).
  - `rst_int_reg` high for 1 cycle.
- `fifo_full` rises on the 2nd LD cycle for 3 cycles:
  - Required sequence: FFS×3, LAF, then back to LD (`parity_done`=0, `low_pkt_valid`=0).
  - `busy`=1 throughout FFS and LAF.
- Packet to port 2 with `fifo_empty_2`=0 for 10 cycles:
  - WTE for 10 cycles, then LFD.
  - A `soft_rst_2` pulse during WTE in a separate run -> DA on the next cycle.
- `data_in`=3 with `pkt_valid`=1 -> stays in DA, `addr_q` unchanged.
- With `ROUTER_FSM_TIMEOUT_EN` defined, `fifo_empty_0` held 0:
  - 64 cycles in WTE, then DA with `drop_pkt`=1 for one cycle.
  - Without the macro: still in WTE after 200 cycles.
